pwm_multi_ch: RTL and testbench

//   Multi-channel PWM generator: CHANNELS independent duty registers share one period counter.

---
 rtl/pwm_multi_ch.sv | 186 ++++++++++++++++++
 tb/tb_pwm_multi_ch.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with a shared edge/center-aligned period counter.
// Per-channel debounced duty buttons; duty and mode commit at period start.
module pwm_multi_ch #(
    parameter int CHANNELS   = 4,
    parameter int CNT_W      = 8,
    parameter int PERIOD     = 10,
    parameter int STEP       = 1,
    parameter int DUTY_RESET = 5,
    parameter int DEBOUNCE   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       increase_duty,
    input  logic [CHANNELS-1:0]       decrease_duty,
    input  logic                      center_mode,
    output logic [CHANNELS-1:0]       PWM_OUT,
    output logic                      period_start,
    output logic [CHANNELS*CNT_W-1:0] duty_flat
);

    localparam int DB_W = $clog2(DEBOUNCE + 1);

    localparam logic [DB_W-1:0]  DB_MAX   = DB_W'(DEBOUNCE);
    localparam logic [DB_W-1:0]  DB_ARM   = DB_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DUTY_TOP = CNT_W'(PERIOD);
    localparam logic [CNT_W-1:0] DUTY_RST = CNT_W'(DUTY_RESET);
    localparam logic [CNT_W:0]   TOP_W    = (CNT_W + 1)'(PERIOD);
    localparam logic [CNT_W:0]   STEP_W   = (CNT_W + 1)'(STEP);

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    dir_e                         dir_q, dir_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         mode_q, mode_d;
    logic                         start_c;
    logic                         mode_eff;

    logic [DB_W-1:0]              inc_db_q [CHANNELS];
    logic [DB_W-1:0]              inc_db_d [CHANNELS];
    logic [DB_W-1:0]              dec_db_q [CHANNELS];
    logic [DB_W-1:0]              dec_db_d [CHANNELS];
    logic [CHANNELS-1:0]          inc_press;
    logic [CHANNELS-1:0]          dec_press;

    logic [CHANNELS-1:0][CNT_W-1:0] pend_q, pend_d;
    logic [CHANNELS-1:0][CNT_W-1:0] act_q, act_d;
    logic [CHANNELS-1:0][CNT_W-1:0] duty_eff;
    logic [CNT_W:0]               up_w [CHANNELS];
    logic [CNT_W:0]               dn_w [CHANNELS];

    logic [CHANNELS-1:0]          pwm_q, pwm_d;
    logic                         ps_q, ps_d;

    // The cycle being produced next is a period start when the counter sits at 0 going up.
    assign start_c  = (cnt_q == '0) && (dir_q == DIR_UP);
    assign mode_eff = start_c ? center_mode : mode_q;

    // Counter direction FSM: state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dir_q  <= DIR_UP;
            cnt_q  <= '0;
            mode_q <= 1'b0;
        end else begin
            dir_q  <= dir_d;
            cnt_q  <= cnt_d;
            mode_q <= mode_d;
        end
    end

    // Counter direction FSM: next state
    always_comb begin
        dir_d = dir_q;
        unique case (dir_q)
            DIR_UP: begin
                if (mode_eff && (cnt_q == CNT_LAST)) begin
                    dir_d = DIR_DOWN;
                end
            end
            DIR_DOWN: begin
                if (cnt_q == '0) begin
                    dir_d = DIR_UP;
                end
            end
            default: dir_d = DIR_UP;
        endcase
    end

    // Counter direction FSM: outputs (count value and committed mode)
    always_comb begin
        cnt_d  = cnt_q;
        mode_d = mode_eff;
        unique case (dir_q)
            DIR_UP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = mode_eff ? cnt_q : '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DIR_DOWN: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: cnt_d = '0;
        endcase
    end

    // A press fires once, on the sample that completes the required run of highs.
    always_comb begin
        inc_press = '0;
        dec_press = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            inc_db_d[c] = '0;
            dec_db_d[c] = '0;
            if (increase_duty[c]) begin
                inc_db_d[c] = (inc_db_q[c] == DB_MAX) ? inc_db_q[c]
                                                       : inc_db_q[c] + 1'b1;
                inc_press[c] = (inc_db_q[c] == DB_ARM);
            end
            if (decrease_duty[c]) begin
                dec_db_d[c] = (dec_db_q[c] == DB_MAX) ? dec_db_q[c]
                                                       : dec_db_q[c] + 1'b1;
                dec_press[c] = (dec_db_q[c] == DB_ARM);
            end
        end
    end

    always_comb begin
        pend_d = pend_q;
        for (int c = 0; c < CHANNELS; c++) begin
            up_w[c] = {1'b0, pend_q[c]} + STEP_W;
            dn_w[c] = {1'b0, pend_q[c]} - STEP_W;
            if (inc_press[c] && !dec_press[c]) begin
                pend_d[c] = (up_w[c] > TOP_W) ? DUTY_TOP
                                              : up_w[c][CNT_W-1:0];
            end else if (dec_press[c] && !inc_press[c]) begin
                pend_d[c] = ({1'b0, pend_q[c]} < STEP_W) ? '0
                                                         : dn_w[c][CNT_W-1:0];
            end
        end
    end

    // The start cycle already uses the newly committed duty.
    always_comb begin
        act_d = start_c ? pend_q : act_q;
        ps_d  = start_c;
        pwm_d = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            duty_eff[c] = act_d[c];
            pwm_d[c]    = (cnt_q < duty_eff[c]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                inc_db_q[c] <= '0;
                dec_db_q[c] <= '0;
                pend_q[c]   <= DUTY_RST;
                act_q[c]    <= DUTY_RST;
            end
            pwm_q <= '0;
            ps_q  <= 1'b0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                inc_db_q[c] <= inc_db_d[c];
                dec_db_q[c] <= dec_db_d[c];
            end
            pend_q <= pend_d;
            act_q  <= act_d;
            pwm_q  <= pwm_d;
            ps_q   <= ps_d;
        end
    end

    assign PWM_OUT      = pwm_q;
    assign period_start = ps_q;
    assign duty_flat    = act_q;

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Bench for pwm_multi_ch: directed scenarios plus random button traffic,
// compared each cycle against a period-position reference model.
module tb_pwm_multi_ch;

    localparam int CH  = 4;
    localparam int W   = 8;
    localparam int P   = 10;
    localparam int S   = 1;
    localparam int DR  = 5;
    localparam int DB  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [CH-1:0]     increase_duty = '0;
    logic [CH-1:0]     decrease_duty = '0;
    logic              center_mode = 1'b0;
    logic [CH-1:0]     PWM_OUT;
    logic              period_start;
    logic [CH*W-1:0]   duty_flat;

    pwm_multi_ch #(
        .CHANNELS(CH), .CNT_W(W), .PERIOD(P),
        .STEP(S), .DUTY_RESET(DR), .DEBOUNCE(DB)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .increase_duty (increase_duty),
        .decrease_duty (decrease_duty),
        .center_mode   (center_mode),
        .PWM_OUT       (PWM_OUT),
        .period_start  (period_start),
        .duty_flat     (duty_flat)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: k is the period position of the next output cycle.
    int            k;
    bit            m_mode;
    int            pend [CH];
    int            act  [CH];
    int            run_i [CH];
    int            run_d [CH];
    logic [CH-1:0] m_pwm;
    logic          m_ps;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [CH*W-1:0] pack_act();
        logic [CH*W-1:0] v = '0;
        for (int c = 0; c < CH; c++) v[c*W +: W] = W'(act[c]);
        return v;
    endfunction

    task automatic model_reset();
        k = 0;
        m_mode = 1'b0;
        m_pwm = '0;
        m_ps = 1'b0;
        for (int c = 0; c < CH; c++) begin
            pend[c] = DR;
            act[c] = DR;
            run_i[c] = 0;
            run_d[c] = 0;
        end
    endtask

    task automatic model_step(input logic [CH-1:0] inc, input logic [CH-1:0] dec,
                              input logic cm);
        int  pos;
        bit  ip, dp;
        m_ps = (k == 0);
        if (m_ps) begin
            for (int c = 0; c < CH; c++) act[c] = pend[c];
            m_mode = cm;
        end
        // Center mode walks 0..P-1 then P-1..0 across 2P cycles.
        if (m_mode) pos = (k < P) ? k : (2 * P - 1 - k);
        else pos = k;
        for (int c = 0; c < CH; c++) m_pwm[c] = (pos < act[c]);
        k = (k + 1) % (m_mode ? 2 * P : P);
        for (int c = 0; c < CH; c++) begin
            ip = inc[c] && (run_i[c] + 1 == DB);
            dp = dec[c] && (run_d[c] + 1 == DB);
            run_i[c] = inc[c] ? ((run_i[c] < DB) ? run_i[c] + 1 : DB) : 0;
            run_d[c] = dec[c] ? ((run_d[c] < DB) ? run_d[c] + 1 : DB) : 0;
            if (ip && !dp) pend[c] = (pend[c] + S > P) ? P : pend[c] + S;
            else if (dp && !ip) pend[c] = (pend[c] - S < 0) ? 0 : pend[c] - S;
        end
    endtask

    task automatic cyc(input logic [CH-1:0] inc, input logic [CH-1:0] dec,
                       input logic cm);
        @(negedge clk);
        check("pwm", 64'(PWM_OUT), 64'(m_pwm));
        check("pstart", 64'(period_start), 64'(m_ps));
        check("duty", 64'(duty_flat), 64'(pack_act()));
        rst = 1'b0;
        increase_duty = inc;
        decrease_duty = dec;
        center_mode = cm;
        model_step(inc, dec, cm);
    endtask

    task automatic idle(input int n, input logic cm);
        repeat (n) cyc('0, '0, cm);
    endtask

    task automatic press(input int ch, input bit up, input logic cm);
        logic [CH-1:0] m = '0;
        m[ch] = 1'b1;
        repeat (5) cyc(up ? m : '0, up ? '0 : m, cm);
        repeat (2) cyc('0, '0, cm);
    endtask

    logic [CH-1:0] r_inc, r_dec;
    logic          r_cm;
    int            highs, starts;

    initial begin
        model_reset();
        idle(30, 1'b0);
        check("reset_duty", 64'(duty_flat), 64'({CH{8'd5}}));

        repeat (12) cyc(4'b0001, '0, 1'b0);
        idle(25, 1'b0);
        check("ch0_one_step", 64'(duty_flat[7:0]), 64'd6);
        check("ch1_untouched", 64'(duty_flat[15:8]), 64'd5);

        repeat (3) cyc(4'b0001, '0, 1'b0);
        cyc('0, '0, 1'b0);
        repeat (3) cyc(4'b0001, '0, 1'b0);
        idle(25, 1'b0);
        check("bounce_ignored", 64'(duty_flat[7:0]), 64'd6);

        repeat (7) press(2, 1'b1, 1'b0);
        idle(25, 1'b0);
        check("ch2_sat_hi", 64'(duty_flat[23:16]), 64'd10);
        repeat (12) press(2, 1'b0, 1'b0);
        idle(25, 1'b0);
        check("ch2_sat_lo", 64'(duty_flat[23:16]), 64'd0);

        repeat (6) cyc(4'b0010, 4'b0010, 1'b0);
        idle(25, 1'b0);
        check("inc_dec_same", 64'(duty_flat[15:8]), 64'd5);

        repeat (2) press(3, 1'b0, 1'b0);
        idle(45, 1'b1);
        highs = 0;
        starts = 0;
        for (int i = 0; i < 40; i++) begin
            cyc('0, '0, 1'b1);
            highs += int'(PWM_OUT[3]);
            starts += int'(period_start);
        end
        check("center_highs", 64'(highs), 64'd12);
        check("center_starts", 64'(starts), 64'd2);

        idle(7, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_pwm", 64'(PWM_OUT), 64'd0);
        check("async_ps", 64'(period_start), 64'd0);
        check("async_duty", 64'(duty_flat), 64'({CH{8'd5}}));
        model_reset();
        idle(25, 1'b0);

        r_inc = '0;
        r_dec = '0;
        r_cm = 1'b0;
        for (int i = 0; i < 800; i++) begin
            for (int c = 0; c < CH; c++) begin
                if ($urandom_range(0, 5) == 0) r_inc[c] = ~r_inc[c];
                if ($urandom_range(0, 5) == 0) r_dec[c] = ~r_dec[c];
            end
            if ($urandom_range(0, 39) == 0) r_cm = ~r_cm;
            cyc(r_inc, r_dec, r_cm);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
